// File: rtl/sga_body_engine.sv
// Snake body store: a segment array (index 0 = head) updated by a multi-cycle shift on each move,
// with a one-cycle init loader and a head-first segment scan stream.
module sga_body_engine #(
  parameter int unsigned MAXLEN = 32
) (
  input  logic                    clock,
  input  logic                    restart,
  input  logic                    init,
  input  logic [7:0]              init_pos,
  input  logic                    move_req,
  input  logic [7:0]              head_pos,
  input  logic                    grow,
  input  logic                    scan_req,
  output logic                    busy,
  output logic                    move_done,
  output logic                    self_collision,
  output logic                    scan_valid,
  output logic [7:0]              scan_pos,
  output logic                    scan_last,
  output logic                    scan_done,
  output logic [$clog2(MAXLEN):0] length
);
  localparam int unsigned IW = $clog2(MAXLEN);
  localparam int unsigned LW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHIFT, S_WRITE_HEAD, S_MOVE_DONE, S_SCAN, S_SCAN_END
  } state_t;

  state_t        state;
  logic [7:0]    mem [MAXLEN];
  logic [IW-1:0] idx;
  logic [LW-1:0] len_new;
  logic [7:0]    head_q;
  logic [LW-1:0] len_calc;
  logic [IW-1:0] idx_dn;
  logic [IW-1:0] idx_up;
  logic          scan_at_tail;

  // Length after a move: an empty body becomes one segment; growth saturates at MAXLEN.
  always_comb begin
    len_calc = length;
    if (length == '0) begin
      len_calc = LW'(1);
    end else if (grow && (length < LW'(MAXLEN))) begin
      len_calc = length + LW'(1);
    end
  end

  assign idx_dn       = idx - IW'(1);
  assign idx_up       = idx + IW'(1);
  assign scan_at_tail = ({1'b0, idx} == (length - LW'(1)));

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state          <= S_IDLE;
      idx            <= '0;
      len_new        <= '0;
      head_q         <= '0;
      length         <= '0;
      busy           <= 1'b0;
      move_done      <= 1'b0;
      self_collision <= 1'b0;
      scan_valid     <= 1'b0;
      scan_pos       <= '0;
      scan_last      <= 1'b0;
      scan_done      <= 1'b0;
      for (int k = 0; k < int'(MAXLEN); k++) mem[k] <= '0;
    end else begin
      move_done <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            head_q <= init_pos;
            state  <= S_INIT;
            busy   <= 1'b1;
          end else if (move_req) begin
            head_q  <= head_pos;
            len_new <= len_calc;
            idx     <= IW'(len_calc - LW'(1));
            state   <= (len_calc > LW'(1)) ? S_SHIFT : S_WRITE_HEAD;
            busy    <= 1'b1;
          end else if (scan_req) begin
            busy <= 1'b1;
            idx  <= '0;
            if (length == '0) begin
              state     <= S_SCAN_END;
              scan_done <= 1'b1;
            end else begin
              state      <= S_SCAN;
              scan_valid <= 1'b1;
              scan_pos   <= mem[0];
              scan_last  <= (length == LW'(1));
            end
          end
        end
        S_INIT: begin
          for (int k = 0; k < int'(MAXLEN); k++) mem[k] <= (k < 3) ? head_q : 8'h00;
          length         <= LW'(3);
          self_collision <= 1'b0;
          state          <= S_IDLE;
          busy           <= 1'b0;
        end
        // Tail-first shift; only segments that survive the move are checked against the new head.
        S_SHIFT: begin
          mem[idx] <= mem[idx_dn];
          if (head_q == mem[idx_dn]) self_collision <= 1'b1;
          if (idx == IW'(1)) state <= S_WRITE_HEAD;
          else               idx   <= idx_dn;
        end
        S_WRITE_HEAD: begin
          mem[0]    <= head_q;
          length    <= len_new;
          move_done <= 1'b1;
          state     <= S_MOVE_DONE;
        end
        S_MOVE_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_SCAN: begin
          if (scan_at_tail) begin
            scan_valid <= 1'b0;
            scan_pos   <= '0;
            scan_last  <= 1'b0;
            scan_done  <= 1'b1;
            state      <= S_SCAN_END;
          end else begin
            idx       <= idx_up;
            scan_pos  <= mem[idx_up];
            scan_last <= ({1'b0, idx_up} == (length - LW'(1)));
          end
        end
        S_SCAN_END: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sga_body_engine.md
SGA_BODY_ENGINE -- requirements
Module: sga_body_engine

Interface
REQ-001 Parameter MAXLEN, default 32, maximum snake length in segments; power of two, 4..64.
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 restart  in  1  reset, asynchronous, active-high.
REQ-004 init  in  1  one-cycle request: load the initial 3-segment body.
REQ-005 init_pos  in  8  initial position {x[7:4],y[3:0]}.
REQ-006 move_req  in  1  one-cycle request: advance the body one step.
REQ-007 head_pos  in  8  new head position, sampled with move_req.
REQ-008 grow  in  1  sampled with move_req; 1 keeps the old tail (length+1).
REQ-009 scan_req  in  1  one-cycle request: stream every segment, head first.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 move_done  out  1  one-cycle pulse when a move completes.
REQ-012 self_collision  out  1  sticky flag: the new head overlaps a body segment.
REQ-013 scan_valid  out  1  scan_pos is valid this cycle.
REQ-014 scan_pos  out  8  segment position being streamed.
REQ-015 scan_last  out  1  high with scan_valid on the final segment.
REQ-016 scan_done  out  1  one-cycle pulse ending a scan.
REQ-017 length  out  log2(MAXLEN)+1  current segment count.

Function
REQ-018 Storage: MAXLEN x 8-bit register array; index 0 is the head and index length-1 is the tail.
REQ-019 FSM states: IDLE, INIT, SHIFT, WRITE_HEAD, MOVE_DONE, SCAN, SCAN_END.
REQ-020 IDLE request priority: init > move_req > scan_req.
- A lower-priority request arriving in the same cycle is dropped.
- Every request is ignored while busy=1.
REQ-021 init: IDLE->INIT.
- INIT (1 cycle): all entries cleared to 0; entries 0..2 = init_pos; length=3; self_collision cleared; then ->IDLE.
REQ-022 move_req in IDLE: capture head_pos and grow.
- Compute len_new = length + (grow && length<MAXLEN ? 1 : 0).
- Set index i = len_new-1.
- Next state SHIFT if len_new>1, else WRITE_HEAD.
REQ-023 SHIFT: mem[i] <= mem[i-1] each cycle.
- If the captured head equals mem[i-1], self_collision <= 1.
- i decrements; leave SHIFT after i=1 -> WRITE_HEAD.
REQ-024 WRITE_HEAD (1 cycle): mem[0] <= captured head; length <= len_new; ->MOVE_DONE.
REQ-025 MOVE_DONE (1 cycle): move_done=1; ->IDLE.
- Latency: move_req at cycle T gives move_done at cycle T+len_new+1.
REQ-026 A move with length=0 writes mem[0] and sets length=1, with no shift cycles.
REQ-027 grow at length=MAXLEN: length is unchanged and the tail is discarded (saturates, no wrap).
REQ-028 self_collision is compared only against the shifted body (new indices 1..len_new-1).
- The discarded tail never triggers it.
- Cleared only by init or restart.
REQ-029 scan_req in IDLE: ->SCAN with index 0, or ->SCAN_END directly if length=0.
REQ-030 SCAN: each cycle drive scan_valid=1 and scan_pos=mem[index].
- scan_last=1 when index=length-1; after that cycle ->SCAN_END.
REQ-031 SCAN_END (1 cycle): scan_done=1; ->IDLE.
REQ-032 When not valid, scan_valid, scan_last and scan_pos are 0; all pulse outputs are registered (Moore).

Reset
REQ-033 restart=1 forces, asynchronously:
- state=IDLE, length=0, all memory entries 0;
- busy, move_done, self_collision, scan_valid, scan_last, scan_done = 0; scan_pos=0.
REQ-034 restart during SHIFT/SCAN aborts the operation.
- No move_done or scan_done follows.
- Memory reads all-zero after release.
REQ-035 After restart deasserts, the first rising edge evaluates IDLE requests normally.

Verification
REQ-036 init, init_pos=8'h55; scan -> length=3; scan_pos 55,55,55, scan_last on 3rd; scan_done next cycle.
REQ-037 After REQ-036, move_req head_pos=8'h56 grow=0 -> move_done 4 cycles later; scan gives 56,55,55; length=3; self_collision=0.
REQ-038 Body 56,55,54,44 (length 4), move_req head 8'h55 grow=1 -> len_new=5, move_done at T+6; self_collision=1; scan 55,56,55,54,44.
REQ-039 Length=MAXLEN, move_req grow=1 -> length stays MAXLEN, old tail lost, move_done at T+MAXLEN+1.
REQ-040 init and move_req in same cycle -> only init executes; move_req during busy -> ignored, no second move_done.
REQ-041 restart mid-SHIFT -> outputs zero immediately; no move_done; scan after release -> scan_done one cycle after entry, no scan_valid.
